// File: rtl/console_port.sv
// Console I/O port responder: status/data ports, RX byte FIFO and a single TX holding register.
// Read side effects (pop, flag clear) happen on the read strobe's falling edge, so the head stays stable.
module console_port #(
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic       ioread,
    input  logic       iowrite,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_out_en,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       irq_rx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ioread_d, iowrite_d;
    logic          pop_pend_q, clr_pend_q;
    logic          overrun_q, txdrop_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          irq_q;

    logic sel_st, sel_dt;
    logic empty, full;
    logic rd_rise, rd_fall, wr_rise;
    logic pop, push, clr, accept, tx_take, tx_drop;
    logic [7:0] head, status;

    assign sel_st  = (address == BASE_ADDR);
    assign sel_dt  = (address == BASE_ADDR + 8'd1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign rd_rise = ioread && !ioread_d;
    assign rd_fall = !ioread && ioread_d;
    assign wr_rise = iowrite && !iowrite_d && sel_dt;

    assign pop     = rd_fall && pop_pend_q && !empty;
    assign clr     = rd_fall && clr_pend_q;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push    = rx_valid && (!full || pop);
    assign accept  = tx_valid_q && tx_ready;
    assign tx_take = wr_rise && (!tx_valid_q || accept);
    assign tx_drop = wr_rise && tx_valid_q && !accept;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    assign head   = empty ? 8'h00 : mem[rptr_q];
    assign status = {4'b0000, txdrop_q, overrun_q, ~tx_valid_q, ~empty};

    always_comb begin
        data_out_en = ioread && (sel_st || sel_dt);
        data_out    = 8'h00;
        if (data_out_en) begin
            data_out = sel_st ? status : head;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign irq_rx   = irq_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ioread_d   <= 1'b1;
            iowrite_d  <= 1'b1;
            pop_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
            txdrop_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ioread_d  <= ioread;
            iowrite_d <= iowrite;
            count_q   <= count_d;
            irq_q     <= (count_d != '0);

            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end

            if (rd_fall) begin
                pop_pend_q <= 1'b0;
                clr_pend_q <= 1'b0;
            end else if (rd_rise) begin
                if (sel_dt && !empty) begin
                    pop_pend_q <= 1'b1;
                end
                if (sel_st) begin
                    clr_pend_q <= 1'b1;
                end
            end

            // Set beats a same-cycle clear for both sticky flags.
            if (rx_valid && !push) begin
                overrun_q <= 1'b1;
            end else if (clr) begin
                overrun_q <= 1'b0;
            end
            if (tx_drop) begin
                txdrop_q <= 1'b1;
            end else if (clr) begin
                txdrop_q <= 1'b0;
            end

            if (tx_take) begin
                tx_data_q  <= data_in;
                tx_valid_q <= 1'b1;
            end else if (accept) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_console_port.sv
// Directed bench for console_port: status/data reads, FIFO overrun and boundary push, TX holding reg.
module tb_console_port;

    localparam logic [7:0] ST = 8'h00;
    localparam logic [7:0] DT = 8'h01;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic       ioread;
    logic       iowrite;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       irq_rx;

    int total = 0;
    int bad   = 0;

    console_port #(
        .BASE_ADDR (8'h00),
        .FIFO_DEPTH(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .ioread     (ioread),
        .iowrite    (iowrite),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_out_en(data_out_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq_rx     (irq_rx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    // Read strobe of len clocks; data_out checked on every strobe clock.
    task automatic rd_strobe(input logic [7:0] addr, input int len, input logic [7:0] exp,
                             input string tag);
        address = addr;
        ioread  = 1'b1;
        for (int i = 0; i < len; i++) begin
            #1;
            chk({tag, "_en"}, 8'(data_out_en), 8'h01);
            chk(tag, data_out, exp);
            tick(1);
        end
        ioread = 1'b0;
        #1;
        chk({tag, "_en_off"}, 8'(data_out_en), 8'h00);
        tick(1);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        address = addr;
        data_in = d;
        iowrite = 1'b1;
        tick(1);
        iowrite = 1'b0;
        tick(1);
    endtask

    initial begin
        reset    = 1'b1;
        address  = 8'h00;
        ioread   = 1'b0;
        iowrite  = 1'b0;
        data_in  = 8'h00;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state and status read
        chk("rst_irq", 8'(irq_rx), 8'h00);
        chk("rst_txv", 8'(tx_valid), 8'h00);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_en", 8'(data_out_en), 8'h00);
        chk("rst_dout", data_out, 8'h00);
        rd_strobe(ST, 1, 8'h02, "st_reset");
        chk("idle_dout", data_out, 8'h00);

        // Head stable across long strobe, one pop per strobe
        push(8'h41);
        push(8'h42);
        tick(1);
        chk("irq_set", 8'(irq_rx), 8'h01);
        rd_strobe(DT, 3, 8'h41, "rd_41");
        rd_strobe(DT, 1, 8'h42, "rd_42");
        rd_strobe(ST, 1, 8'h02, "st_drained");
        chk("irq_clr", 8'(irq_rx), 8'h00);
        rd_strobe(DT, 1, 8'h00, "rd_empty");

        // Overrun on 9th byte, cleared by status read
        for (int i = 1; i <= 9; i++) push(8'(8'h10 + i));
        rd_strobe(ST, 1, 8'h07, "st_ovr");
        rd_strobe(ST, 1, 8'h03, "st_ovr_clr");
        for (int i = 1; i <= 8; i++) rd_strobe(DT, 1, 8'(8'h10 + i), "drain_ovr");
        rd_strobe(ST, 1, 8'h02, "st_after_ovr");

        // Push into a full FIFO on the pop cycle is accepted
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        address = DT;
        ioread  = 1'b1;
        tick(2);
        ioread   = 1'b0;
        rx_data  = 8'h28;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(1);
        rd_strobe(ST, 1, 8'h03, "st_full_popush");
        for (int i = 1; i <= 8; i++) rd_strobe(DT, 1, 8'(8'h20 + i), "drain_full");
        rd_strobe(ST, 1, 8'h02, "st_full_empty");

        // TX holding register, drop, accept, write on accept cycle
        wr(ST, 8'h77);
        chk("st_wr_ignored", 8'(tx_valid), 8'h00);
        wr(DT, 8'h55);
        chk("tx_55_v", 8'(tx_valid), 8'h01);
        chk("tx_55_d", tx_data, 8'h55);
        wr(DT, 8'hAA);
        chk("tx_hold_d", tx_data, 8'h55);
        rd_strobe(ST, 1, 8'h08, "st_txdrop");
        rd_strobe(ST, 1, 8'h00, "st_txdrop_clr");
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        chk("tx_accept", 8'(tx_valid), 8'h00);
        wr(DT, 8'h11);
        address  = DT;
        data_in  = 8'h22;
        iowrite  = 1'b1;
        tx_ready = 1'b1;
        tick(1);
        iowrite  = 1'b0;
        tx_ready = 1'b0;
        chk("tx_same_cyc_v", 8'(tx_valid), 8'h01);
        chk("tx_same_cyc_d", tx_data, 8'h22);
        rd_strobe(ST, 1, 8'h00, "st_same_cyc");
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;

        // Reset in the middle of a data read strobe
        push(8'h5A);
        address = DT;
        ioread  = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("rst_mid_en", 8'(data_out_en), 8'h01);
        chk("rst_mid_dout", data_out, 8'h00);
        reset = 1'b0;
        tick(1);
        push(8'h6B);
        #1;
        chk("rst_mid_head", data_out, 8'h6B);
        ioread = 1'b0;
        #1;
        chk("rst_mid_en_off", 8'(data_out_en), 8'h00);
        tick(2);
        rd_strobe(ST, 1, 8'h03, "st_no_pop");
        rd_strobe(DT, 1, 8'h6B, "rd_6b");
        rd_strobe(ST, 1, 8'h02, "st_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
